// File: rtl/regfile_sb.sv
// regfile_sb: 31 x 64-bit integer register file (x0 hardwired to zero) with
// two read pairs for a dual-issue front end. It also has a load scoreboard:
// a busy bit per register that is set when a load issues and cleared when the
// load writes back. The scoreboard drives a load-use stall request. Read data
// is not bypassed internally. Same-cycle writeback is forwarded downstream.

package regfile_sb_pkg;
    localparam int XLEN  = 64;
    localparam int NREGS = 32;

    typedef logic [4:0]      regaddr_t;
    typedef logic [XLEN-1:0] data_t;
endpackage

module regfile_sb
    import regfile_sb_pkg::*;
(
    input  logic     clk,
    input  logic     resetn,

    input  regaddr_t raddr1,
    input  regaddr_t raddr2,
    input  regaddr_t raddr3,
    input  regaddr_t raddr4,
    input  logic     ren1,
    input  logic     ren2,
    input  logic     ren3,
    input  logic     ren4,
    output data_t    rdata1,
    output data_t    rdata2,
    output data_t    rdata3,
    output data_t    rdata4,

    input  logic     wen1,
    input  regaddr_t waddr1,
    input  data_t    wdata1,
    input  logic     wen2,
    input  regaddr_t waddr2,
    input  data_t    wdata2,

    input  logic     set_en1,
    input  regaddr_t set_addr1,
    input  logic     set_en2,
    input  regaddr_t set_addr2,
    input  logic     clr_en1,
    input  regaddr_t clr_addr1,
    input  logic     clr_en2,
    input  regaddr_t clr_addr2,
    input  logic     flush,

    output logic     busy1,
    output logic     busy2,
    output logic     busy3,
    output logic     busy4,
    output logic     load_use_stall
);

    // x1..x31 only; x0 has no storage and reads as zero.
    data_t            regs [1:NREGS-1];
    data_t            rf_view [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    // Register array: the younger writeback slot (2) wins on an address clash.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            // NOTE: this storage must clear asynchronously, so it is built from
            // resettable flops. A RAM macro could not be cleared like this.
            for (int i = 1; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            // NOTE: state is updated with non-blocking assignments, so every
            // flop samples the values from before the edge.
            for (int i = 1; i < NREGS; i++) begin
                if (wen2 && (waddr2 == regaddr_t'(i))) begin
                    regs[i] <= wdata2;
                end else if (wen1 && (waddr1 == regaddr_t'(i))) begin
                    regs[i] <= wdata1;
                end
            end
        end
    end

    // Next busy vector. Clears are applied first so that a set to the same
    // register wins. A flush wipes everything and drops this cycle's sets.
    always_comb begin
        // NOTE: the default assignment comes first, so every path assigns
        // busy_d and no latch is inferred.
        busy_d = busy_q;
        if (clr_en1) busy_d[clr_addr1] = 1'b0;
        if (clr_en2) busy_d[clr_addr2] = 1'b0;
        if (flush) begin
            busy_d = '0;
        end else begin
            if (set_en1) busy_d[set_addr1] = 1'b1;
            if (set_en2) busy_d[set_addr2] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Busy vector register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Full 32-entry read view with x0 tied to zero. Each read port is then a
    // plain index into this view.
    always_comb begin
        rf_view[0] = '0;
        for (int i = 1; i < NREGS; i++) begin
            rf_view[i] = regs[i];
        end
    end

    assign rdata1 = rf_view[raddr1];
    assign rdata2 = rf_view[raddr2];
    assign rdata3 = rf_view[raddr3];
    assign rdata4 = rf_view[raddr4];

    assign busy1 = busy_q[raddr1];
    assign busy2 = busy_q[raddr2];
    assign busy3 = busy_q[raddr3];
    assign busy4 = busy_q[raddr4];

    assign load_use_stall = (ren1 & busy1) | (ren2 & busy2)
                          | (ren3 & busy3) | (ren4 & busy4);

endmodule
